// File: rtl/answer_period_if.sv
// answer_period_if: handshake and display bundle of the answer-window timer.
//   slave  - seen from the timer (answerSig in, pulse/level/segments out)
//   master - seen from the quiz controller / display driver
interface answer_period_if;

  // Opens the answer window (one-cycle pulse).
  logic       answerSig;
  // One-cycle pulse when the window ends.
  logic       postSig;
  // High for the whole window; freezes the main counter.
  logic       stopCount;
  // Active-low 7-segment codes, bit7 = dp, bits 6..0 = g..a.
  logic [7:0] answerSeg0;
  logic [7:0] answerSeg1;
  logic [7:0] answerSeg2;
  logic [7:0] answerSeg3;

  modport slave (
    input  answerSig,
    output postSig,
    output stopCount,
    output answerSeg0,
    output answerSeg1,
    output answerSeg2,
    output answerSeg3
  );

  modport master (
    output answerSig,
    input  postSig,
    input  stopCount,
    input  answerSeg0,
    input  answerSeg1,
    input  answerSeg2,
    input  answerSeg3
  );

endinterface : answer_period_if

// File: rtl/answer_period.sv
// answer_period: answer-window timer for the SymCounter quiz display.
//   A one-cycle answerSig pulse opens a countdown of ANSWER_SECS seconds,
//   counted on Clk1Hz ticks. stopCount is high for the whole window and
//   postSig pulses for one cycle when it expires. The remaining seconds and
//   an "An" tag are shown on four active-low 7-segment digits.
// Parameter:
//   ANSWER_SECS - window length in seconds, legal range 1..99.
// Optional feature macro:
//   ANSWER_EARLY_STOP_EN - when defined, answerSig during the window ends it
//   at the next edge with the same outputs as a normal expiry.
// All logic runs on the rising edge of Clk100M; Rst_n is asynchronous,
// active-low, and aborts a running window without producing postSig.
module answer_period #(
  parameter int ANSWER_SECS = 30
) (
  input  logic            Clk100M,
  input  logic            Rst_n,
  input  logic            Clk1Hz,
  answer_period_if.slave  ap
);

  // Window length as a 7-bit load value.
  localparam logic [6:0] SECS_LOAD = 7'(ANSWER_SECS);

  // Segment codes (active-low, dp off).
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_N     = 8'hAB;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_ANSWERING = 1'b1
  } state_t;

  // Registered state.
  state_t      r_state;
  logic [6:0]  r_remaining;
  logic        r_post;
  logic        r_stop;

  // Next-state values.
  state_t      w_state_nxt;
  logic [6:0]  w_remaining_nxt;
  logic        w_post_nxt;
  logic        w_stop_nxt;

  // Decoded display.
  logic [7:0]  w_seg0;
  logic [7:0]  w_seg1;
  logic [7:0]  w_seg2;
  logic [7:0]  w_seg3;

  // Decimal digit to active-low 7-segment code; out-of-range codes blank.
  function automatic logic [7:0] seg_digit(input logic [3:0] digit);
    logic [7:0] code;
    case (digit)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = 8'hFF;
    endcase
    return code;
  endfunction

  // Tens digit of a 0..99 value.
  function automatic logic [3:0] tens_of(input logic [6:0] value);
    logic [6:0] quot;
    quot = value / 7'd10;
    return quot[3:0];
  endfunction

  // Units digit of a 0..99 value.
  function automatic logic [3:0] units_of(input logic [6:0] value);
    logic [6:0] quot;
    logic [6:0] rem;
    quot = value / 7'd10;
    rem  = value - (quot * 7'd10);
    return rem[3:0];
  endfunction

  // State, counter and output registers; reset aborts any running window.
  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= ST_IDLE;
      r_remaining <= 7'd0;
      r_post      <= 1'b0;
      r_stop      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_post      <= w_post_nxt;
      r_stop      <= w_stop_nxt;
    end
  end

  // Next-state logic: open on answerSig, count down on ticks, close with one postSig.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_post_nxt      = 1'b0;
    w_stop_nxt      = r_stop;

    case (r_state)
      ST_IDLE: begin
        // A tick coinciding with the opening pulse is deliberately dropped,
        // so the first displayed value is always the full window length.
        if (ap.answerSig) begin
          w_state_nxt     = ST_ANSWERING;
          w_remaining_nxt = SECS_LOAD;
          w_stop_nxt      = 1'b1;
        end else begin
          w_state_nxt     = ST_IDLE;
          w_remaining_nxt = 7'd0;
          w_stop_nxt      = 1'b0;
        end
      end

      ST_ANSWERING: begin
`ifdef ANSWER_EARLY_STOP_EN
        // Early stop and final tick share one close-out path, so a
        // coincident pair still yields a single postSig.
        if (ap.answerSig || (Clk1Hz && (r_remaining <= 7'd1))) begin
          w_state_nxt     = ST_IDLE;
          w_remaining_nxt = 7'd0;
          w_stop_nxt      = 1'b0;
          w_post_nxt      = 1'b1;
        end else if (Clk1Hz) begin
          w_remaining_nxt = r_remaining - 7'd1;
        end else begin
          w_remaining_nxt = r_remaining;
        end
`else
        if (Clk1Hz) begin
          if (r_remaining > 7'd1) begin
            w_remaining_nxt = r_remaining - 7'd1;
          end else begin
            // Last second elapsed (a zero count is also closed out safely).
            w_state_nxt     = ST_IDLE;
            w_remaining_nxt = 7'd0;
            w_stop_nxt      = 1'b0;
            w_post_nxt      = 1'b1;
          end
        end else begin
          w_remaining_nxt = r_remaining;
        end
`endif
      end

      default: begin
        // Unreachable encoding: fall back to a quiet idle.
        w_state_nxt     = ST_IDLE;
        w_remaining_nxt = 7'd0;
        w_stop_nxt      = 1'b0;
        w_post_nxt      = 1'b0;
      end
    endcase
  end

  // Display decode from registered state: blank when idle, "An" + seconds when answering.
  always_comb begin
    w_seg0 = SEG_BLANK;
    w_seg1 = SEG_BLANK;
    w_seg2 = SEG_BLANK;
    w_seg3 = SEG_BLANK;
    if (r_state == ST_ANSWERING) begin
      w_seg3 = SEG_A;
      w_seg2 = SEG_N;
      // Tens digit 0 is shown as '0', not blanked.
      w_seg1 = seg_digit(tens_of(r_remaining));
      w_seg0 = seg_digit(units_of(r_remaining));
    end else begin
      w_seg0 = SEG_BLANK;
      w_seg1 = SEG_BLANK;
      w_seg2 = SEG_BLANK;
      w_seg3 = SEG_BLANK;
    end
  end

  assign ap.postSig    = r_post;
  assign ap.stopCount  = r_stop;
  assign ap.answerSeg0 = w_seg0;
  assign ap.answerSeg1 = w_seg1;
  assign ap.answerSeg2 = w_seg2;
  assign ap.answerSeg3 = w_seg3;

endmodule : answer_period

// File: tb/tb_answer_period.sv
// tb_answer_period: directed self-checking bench for answer_period
// (ANSWER_SECS = 30, one Clk1Hz tick every 100 clocks).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_answer_period;

  logic Clk100M;
  logic Rst_n;
  logic Clk1Hz;

  int n_checks;
  int n_fail;
  int post_count;

  answer_period_if ap ();

  answer_period #(
    .ANSWER_SECS (30)
  ) dut (
    .Clk100M (Clk100M),
    .Rst_n   (Rst_n),
    .Clk1Hz  (Clk1Hz),
    .ap      (ap.slave)
  );

  // 100 MHz clock.
  initial begin
    Clk100M = 1'b0;
    forever #5 Clk100M = ~Clk100M;
  end

  // Count every cycle in which postSig is seen high.
  always @(negedge Clk100M) begin
    if (ap.postSig === 1'b1) post_count = post_count + 1;
  end

  // 99 quiet cycles then one cycle with Clk1Hz high, n times.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (99) @(negedge Clk100M);
      Clk1Hz = 1'b1;
      @(negedge Clk100M);
      Clk1Hz = 1'b0;
    end
  endtask

  // One-cycle answerSig pulse.
  task automatic pulse_answer();
    ap.answerSig = 1'b1;
    @(negedge Clk100M);
    ap.answerSig = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    Clk1Hz = 1'b0;
    ap.answerSig = 1'b0;
    repeat (3) @(negedge Clk100M);
    n_checks++;
    if (ap.postSig !== 1'b0) begin
      n_fail++; $display("FAIL reset_post: got %b expected 0", ap.postSig);
    end
    n_checks++;
    if (ap.stopCount !== 1'b0) begin
      n_fail++; $display("FAIL reset_stop: got %b expected 0", ap.stopCount);
    end
    n_checks++;
    if ({ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0} !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL reset_segs: got %h expected FFFFFFFF",
               {ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0});
    end
    Rst_n = 1'b1;
    repeat (20) @(negedge Clk100M);
    tick_n(1);
    repeat (5) @(negedge Clk100M);
    n_checks++;
    if (ap.stopCount !== 1'b0 || ap.postSig !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_release: got stop=%b post=%b expected 0/0", ap.stopCount, ap.postSig);
    end
    n_checks++;
    if ({ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0} !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL idle_segs: got %h expected FFFFFFFF",
               {ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0});
    end
  endtask

  // Full 30 s window, then an immediate restart in the postSig cycle.
  task automatic test_window();
    int base;
    base = post_count;
    pulse_answer();
    n_checks++;
    if (ap.stopCount !== 1'b1 || ap.postSig !== 1'b0) begin
      n_fail++;
      $display("FAIL open_levels: got stop=%b post=%b expected 1/0", ap.stopCount, ap.postSig);
    end
    n_checks++;
    if ({ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0} !== 32'h88ABB0C0) begin
      n_fail++;
      $display("FAIL open_segs_30: got %h expected 88ABB0C0",
               {ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0});
    end
    tick_n(1);
    n_checks++;
    if ({ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0} !== 32'h88ABA490) begin
      n_fail++;
      $display("FAIL segs_29: got %h expected 88ABA490",
               {ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0});
    end
    tick_n(9);
    n_checks++;
    if ({ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0} !== 32'h88ABA4C0) begin
      n_fail++;
      $display("FAIL segs_20: got %h expected 88ABA4C0",
               {ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0});
    end
    tick_n(19);
    n_checks++;
    if ({ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0} !== 32'h88ABC0F9
        || ap.stopCount !== 1'b1 || ap.postSig !== 1'b0) begin
      n_fail++;
      $display("FAIL segs_01: got %h stop=%b post=%b expected 88ABC0F9 1 0",
               {ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0}, ap.stopCount, ap.postSig);
    end
    tick_n(1);
    n_checks++;
    if (ap.postSig !== 1'b1 || ap.stopCount !== 1'b0) begin
      n_fail++;
      $display("FAIL expiry_levels: got post=%b stop=%b expected 1/0", ap.postSig, ap.stopCount);
    end
    n_checks++;
    if ({ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0} !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL expiry_segs: got %h expected FFFFFFFF",
               {ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0});
    end
    // Back-to-back: reopen in the very cycle postSig is high.
    pulse_answer();
    n_checks++;
    if (ap.postSig !== 1'b0 || ap.stopCount !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_levels: got post=%b stop=%b expected 0/1", ap.postSig, ap.stopCount);
    end
    n_checks++;
    if ({ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0} !== 32'h88ABB0C0) begin
      n_fail++;
      $display("FAIL b2b_segs_30: got %h expected 88ABB0C0",
               {ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0});
    end
    n_checks++;
    if (post_count - base !== 1) begin
      n_fail++; $display("FAIL post_pulse_count: got %0d expected 1", post_count - base);
    end
    tick_n(30);
    n_checks++;
    if (ap.postSig !== 1'b1) begin
      n_fail++; $display("FAIL b2b_expiry: got post=%b expected 1", ap.postSig);
    end
    @(negedge Clk100M);
  endtask

  // answerSig and Clk1Hz together in IDLE: the tick is ignored.
  task automatic test_coincident();
    ap.answerSig = 1'b1;
    Clk1Hz = 1'b1;
    @(negedge Clk100M);
    ap.answerSig = 1'b0;
    Clk1Hz = 1'b0;
    n_checks++;
    if ({ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0} !== 32'h88ABB0C0) begin
      n_fail++;
      $display("FAIL coincident_start_30: got %h expected 88ABB0C0",
               {ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0});
    end
    tick_n(1);
    n_checks++;
    if ({ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0} !== 32'h88ABA490) begin
      n_fail++;
      $display("FAIL coincident_29: got %h expected 88ABA490",
               {ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0});
    end
    tick_n(29);
    n_checks++;
    if (ap.postSig !== 1'b1 || ap.stopCount !== 1'b0) begin
      n_fail++;
      $display("FAIL coincident_expiry: got post=%b stop=%b expected 1/0", ap.postSig, ap.stopCount);
    end
    @(negedge Clk100M);
    n_checks++;
    if (ap.postSig !== 1'b0) begin
      n_fail++; $display("FAIL post_single_cycle: got %b expected 0", ap.postSig);
    end
  endtask

  // answerSig in the middle of a window, at remaining = 12.
  task automatic test_answer_mid();
    pulse_answer();
    tick_n(18);
    n_checks++;
    if ({ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0} !== 32'h88ABF9A4) begin
      n_fail++;
      $display("FAIL mid_segs_12: got %h expected 88ABF9A4",
               {ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0});
    end
    pulse_answer();
`ifdef ANSWER_EARLY_STOP_EN
    n_checks++;
    if (ap.postSig !== 1'b1 || ap.stopCount !== 1'b0) begin
      n_fail++;
      $display("FAIL early_stop: got post=%b stop=%b expected 1/0", ap.postSig, ap.stopCount);
    end
    @(negedge Clk100M);
    // Early stop coinciding with the final tick: one postSig only.
    pulse_answer();
    tick_n(29);
    begin
      int base;
      base = post_count;
      ap.answerSig = 1'b1;
      Clk1Hz = 1'b1;
      @(negedge Clk100M);
      ap.answerSig = 1'b0;
      Clk1Hz = 1'b0;
      n_checks++;
      if (ap.postSig !== 1'b1 || ap.stopCount !== 1'b0) begin
        n_fail++;
        $display("FAIL early_final_levels: got post=%b stop=%b expected 1/0", ap.postSig, ap.stopCount);
      end
      repeat (5) @(negedge Clk100M);
      n_checks++;
      if (post_count - base !== 1) begin
        n_fail++; $display("FAIL early_final_count: got %0d expected 1", post_count - base);
      end
    end
`else
    n_checks++;
    if (ap.postSig !== 1'b0 || ap.stopCount !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_ignored_levels: got post=%b stop=%b expected 0/1", ap.postSig, ap.stopCount);
    end
    n_checks++;
    if ({ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0} !== 32'h88ABF9A4) begin
      n_fail++;
      $display("FAIL mid_ignored_segs: got %h expected 88ABF9A4",
               {ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0});
    end
    tick_n(11);
    n_checks++;
    if (ap.stopCount !== 1'b1 || ap.postSig !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_not_yet_expired: got stop=%b post=%b expected 1/0", ap.stopCount, ap.postSig);
    end
    tick_n(1);
    n_checks++;
    if (ap.postSig !== 1'b1 || ap.stopCount !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_expiry: got post=%b stop=%b expected 1/0", ap.postSig, ap.stopCount);
    end
    @(negedge Clk100M);
`endif
  endtask

  // Reset in mid-window at remaining = 5, then restart.
  task automatic test_reset_mid();
    int base;
    pulse_answer();
    tick_n(25);
    n_checks++;
    if ({ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0} !== 32'h88ABC092) begin
      n_fail++;
      $display("FAIL segs_05: got %h expected 88ABC092",
               {ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0});
    end
    repeat (10) @(negedge Clk100M);
    base = post_count;
    Rst_n = 1'b0;
    #1;
    n_checks++;
    if (ap.postSig !== 1'b0 || ap.stopCount !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_levels: got post=%b stop=%b expected 0/0", ap.postSig, ap.stopCount);
    end
    n_checks++;
    if ({ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0} !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL abort_segs: got %h expected FFFFFFFF",
               {ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0});
    end
    repeat (5) @(negedge Clk100M);
    Rst_n = 1'b1;
    tick_n(2);
    n_checks++;
    if (post_count - base !== 0 || ap.stopCount !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_post: got posts=%0d stop=%b expected 0/0", post_count - base, ap.stopCount);
    end
    pulse_answer();
    n_checks++;
    if ({ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0} !== 32'h88ABB0C0
        || ap.stopCount !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_30: got %h stop=%b expected 88ABB0C0 1",
               {ap.answerSeg3, ap.answerSeg2, ap.answerSeg1, ap.answerSeg0}, ap.stopCount);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    post_count = 0;
    Rst_n = 1'b0;
    Clk1Hz = 1'b0;
    ap.answerSig = 1'b0;
    @(negedge Clk100M);
    test_reset();
    test_window();
    test_coincident();
    test_answer_mid();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_answer_period
